// File: rtl/ring_rr_arbiter_pkg.sv
// Shared types and helpers for the ring round-robin arbiter.
// Optional hold-time limit is enabled with the RING_ARB_TIMEOUT_EN macro.
package ring_arb_pkg;

    localparam int RING_ARB_DEFAULT_N = 4;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    // Rotate a one-hot value left by one within an n-bit ring (n <= 16).
    function automatic logic [15:0] rotl_onehot(input logic [15:0] v, input int n);
        logic [15:0] mask;
        mask = (16'd1 << n) - 16'd1;
        return ((v << 1) | (v >> (n - 1))) & mask;
    endfunction

    // Binary index of a one-hot value (zero input gives zero).
    function automatic logic [3:0] onehot2bin(input logic [15:0] v);
        logic [3:0] r;
        r[0] = |(v & 16'hAAAA);
        r[1] = |(v & 16'hCCCC);
        r[2] = |(v & 16'hF0F0);
        r[3] = |(v & 16'hFF00);
        return r;
    endfunction

endpackage

// File: rtl/ring_rr_arbiter_if.sv
// Requester/arbiter bus for the ring round-robin arbiter.
// The timeout signal exists only when RING_ARB_TIMEOUT_EN is defined.
interface ring_rr_arbiter_if #(parameter int N = 4);

    localparam int IW = $clog2(N);

    logic [N-1:0]  req;
    logic [N-1:0]  done;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_id;
`ifdef RING_ARB_TIMEOUT_EN
    logic          timeout;

    modport master (output req, done, input gnt, gnt_valid, gnt_id, timeout);
    modport slave  (input req, done, output gnt, gnt_valid, gnt_id, timeout);
`else
    modport master (output req, done, input gnt, gnt_valid, gnt_id);
    modport slave  (input req, done, output gnt, gnt_valid, gnt_id);
`endif

endinterface

// File: rtl/ring_rr_arbiter_token_reg.sv
// One-hot ring priority token. Reset parks it on bit 0; when en is high the
// token steps to the position just past the current owner (owner+1, wrapping).
module ring_token_reg
    import ring_arb_pkg::*;
#(
    parameter int N = RING_ARB_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] owner,
    output logic [N-1:0] token
);

    logic [15:0] step;

    assign step = rotl_onehot(16'(owner), N);

    // Token register: advances only on a release.
    always_ff @(posedge clk) begin
        if (rst)
            token <= N'(1);
        else if (en)
            token <= N'(step);
    end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot ring token. Grants are registered, held
// until the owner releases, and handed over on the release edge with no bubble.
// Define RING_ARB_TIMEOUT_EN to force release after MAX_HOLD grant cycles.
module ring_rr_arbiter
    import ring_arb_pkg::*;
#(
    parameter int N = RING_ARB_DEFAULT_N
`ifdef RING_ARB_TIMEOUT_EN
    , parameter int MAX_HOLD = 8
`endif
) (
    input  logic clk,
    input  logic rst,
    ring_rr_arbiter_if.slave bus
);

    localparam int IW = $clog2(N);
    localparam logic [N-1:0] ONE = N'(1);

    arb_state_t    state, state_nxt;
    logic [N-1:0]  token;
    logic [N-1:0]  gnt_p1, gnt_nxt;
    logic [IW-1:0] id_p1;
    logic          vld_p1;
    logic [N-1:0]  srch_tok, hi, winner;
    logic [3:0]    id_full;
    logic          owner_rel, rel;

`ifdef RING_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    logic [HW-1:0] hold_cnt;
    logic          forced;
    logic          timeout_p1;
`endif

    ring_token_reg #(.N(N)) u_token (
        .clk   (clk),
        .rst   (rst),
        .en    (rel),
        .owner (gnt_p1),
        .token (token)
    );

    // While granted, search starts from the token the release will produce.
    assign srch_tok = (state == GRANT) ? N'(rotl_onehot(16'(gnt_p1), N)) : token;

    // Circular priority search: lowest request at/above the token, else lowest overall.
    always_comb begin
        hi = bus.req & ~(srch_tok - ONE);
        if (|hi)
            winner = hi & (~hi + ONE);
        else
            winner = bus.req & (~bus.req + ONE);
    end

    // Next-state and next-grant decision.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_p1;
        owner_rel = 1'b0;
        rel       = 1'b0;
`ifdef RING_ARB_TIMEOUT_EN
        forced    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    gnt_nxt   = winner;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                owner_rel = (|(gnt_p1 & bus.done)) | ~(|(gnt_p1 & bus.req));
`ifdef RING_ARB_TIMEOUT_EN
                forced    = ~owner_rel & (hold_cnt == HOLD_LAST);
                rel       = owner_rel | forced;
`else
                rel       = owner_rel;
`endif
                if (rel) begin
                    if (|bus.req) begin
                        gnt_nxt = winner;
                    end else begin
                        gnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign id_full = onehot2bin(16'(gnt_nxt));

    // Grant stage: state, grant, index and valid all update on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            gnt_p1 <= '0;
            id_p1  <= '0;
            vld_p1 <= 1'b0;
        end else begin
            state  <= state_nxt;
            gnt_p1 <= gnt_nxt;
            id_p1  <= IW'(id_full);
            vld_p1 <= |gnt_nxt;
        end
    end

`ifdef RING_ARB_TIMEOUT_EN
    // Hold counter: cleared on release/idle, counts grant cycles otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt   <= '0;
            timeout_p1 <= 1'b0;
        end else begin
            timeout_p1 <= forced;
            if (state == IDLE || rel)
                hold_cnt <= '0;
            else
                hold_cnt <= hold_cnt + HW'(1);
        end
    end

    assign bus.timeout = timeout_p1;
`endif

    assign bus.gnt       = gnt_p1;
    assign bus.gnt_id    = id_p1;
    assign bus.gnt_valid = vld_p1;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Bench for ring_rr_arbiter: directed scenarios plus randomized traffic,
// all checked against a cycle model built from the arbitration rules.
// Define RING_ARB_TIMEOUT_EN to include the hold-limit scenarios.
module tb_ring_rr_arbiter;

    localparam int N = 4;
`ifdef RING_ARB_TIMEOUT_EN
    localparam int MAX_HOLD = 8;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ring_rr_arbiter_if #(.N(N)) bus ();

`ifdef RING_ARB_TIMEOUT_EN
    ring_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`else
    ring_rr_arbiter #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: granted flag, owner index, token index, hold count.
    bit m_g;
    int m_o;
    int m_t;
    int m_h;
`ifdef RING_ARB_TIMEOUT_EN
    bit m_to;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit bit_at(input logic [N-1:0] v, input int i);
        return ((v >> i) & N'(1)) != '0;
    endfunction

    // First requester at or after position t going round the ring.
    function automatic int search(input logic [N-1:0] r, input int t);
        for (int k = 0; k < N; k++) begin
            if (bit_at(r, (t + k) % N))
                return (t + k) % N;
        end
        return 0;
    endfunction

    // Advance model and DUT by one edge, then compare all outputs.
    task automatic tick();
        bit ng, reln, frc, nto;
        int no, nt, nh;
        ng = m_g; no = m_o; nt = m_t; nh = m_h; nto = 1'b0; frc = 1'b0;
        if (rst) begin
            ng = 1'b0; no = 0; nt = 0; nh = 0;
        end else if (!m_g) begin
            if (bus.req != '0) begin
                ng = 1'b1; no = search(bus.req, m_t); nh = 0;
            end
        end else begin
            reln = bit_at(bus.done, m_o) || !bit_at(bus.req, m_o);
`ifdef RING_ARB_TIMEOUT_EN
            frc = !reln && (m_h == MAX_HOLD - 1);
`endif
            if (reln || frc) begin
                nt  = (m_o + 1) % N;
                nto = frc;
                nh  = 0;
                if (bus.req != '0) no = search(bus.req, nt);
                else begin ng = 1'b0; no = 0; end
            end else begin
                nh = m_h + 1;
            end
        end
        @(posedge clk);
        #1;
        m_g = ng; m_o = no; m_t = nt; m_h = nh;
`ifdef RING_ARB_TIMEOUT_EN
        m_to = nto;
        check("timeout", 32'(bus.timeout), 32'(m_to));
`endif
        check("gnt", 32'(bus.gnt), m_g ? (32'd1 << m_o) : 32'd0);
        check("gnt_valid", 32'(bus.gnt_valid), 32'(m_g));
        check("gnt_id", 32'(bus.gnt_id), m_g ? 32'(m_o) : 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.req = '0; bus.done = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] seq [4];
        seq[0] = 4'b0010; seq[1] = 4'b0100; seq[2] = 4'b1000; seq[3] = 4'b0001;
        m_g = 1'b0; m_o = 0; m_t = 0; m_h = 0;
`ifdef RING_ARB_TIMEOUT_EN
        m_to = 1'b0;
`endif
        rst = 1'b1; bus.req = '0; bus.done = '0;

        // Reset with all requesting, then first grant to bit 0.
        bus.req = 4'b1111;
        tick();
        tick();
        check("t1_rst_gnt", 32'(bus.gnt), 32'd0);
        check("t1_rst_vld", 32'(bus.gnt_valid), 32'd0);
        rst = 1'b0;
        tick();
        check("t1_first_gnt", 32'(bus.gnt), 32'b0001);

        // Rotation with owner done pulses, no idle between grants.
        for (int i = 0; i < 4; i++) begin
            bus.done = bus.gnt;
            tick();
            check("t2_rotate", 32'(bus.gnt), 32'(seq[i]));
        end
        bus.done = '0;

        // Skip and wrap from token at bit 2.
        do_reset();
        bus.req = 4'b0010;
        tick();
        bus.done = 4'b0010; bus.req = 4'b0000;
        tick();
        bus.done = '0; bus.req = 4'b0011;
        tick();
        check("t3_wrap", 32'(bus.gnt), 32'b0001);
        bus.done = 4'b0001;
        tick();
        check("t3_next", 32'(bus.gnt), 32'b0010);
        bus.done = '0;

        // Sole requester is re-granted; token moves past it.
        do_reset();
        bus.req = 4'b0100;
        tick();
        bus.done = 4'b0100;
        tick();
        check("t4_regrant", 32'(bus.gnt), 32'b0100);
        bus.done = '0; bus.req = '0;
        tick();
        check("t4_idle_gnt", 32'(bus.gnt), 32'd0);
        check("t4_idle_vld", 32'(bus.gnt_valid), 32'd0);
        bus.req = 4'b1001;
        tick();
        check("t4_token_pos", 32'(bus.gnt), 32'b1000);

        // Reset in the middle of a grant.
        do_reset();
        bus.req = 4'b0100;
        tick();
        rst = 1'b1;
        tick();
        check("t5_rst_gnt", 32'(bus.gnt), 32'd0);
        rst = 1'b0;
        tick();
        check("t5_regnt", 32'(bus.gnt), 32'b0100);
        check("t5_id", 32'(bus.gnt_id), 32'd2);

`ifdef RING_ARB_TIMEOUT_EN
        // Forced release after MAX_HOLD cycles.
        do_reset();
        bus.req = 4'b0011;
        tick();
        for (int i = 0; i < MAX_HOLD - 1; i++) begin
            tick();
            check("t6_held", 32'(bus.gnt), 32'b0001);
        end
        tick();
        check("t6_to_pulse", 32'(bus.timeout), 32'd1);
        check("t6_to_gnt", 32'(bus.gnt), 32'b0010);
        tick();
        check("t6_to_clear", 32'(bus.timeout), 32'd0);
        // Done on the limit cycle is a normal release.
        do_reset();
        bus.req = 4'b0011;
        tick();
        for (int i = 0; i < MAX_HOLD - 1; i++) tick();
        bus.done = 4'b0001;
        tick();
        check("t6_done_to", 32'(bus.timeout), 32'd0);
        check("t6_done_gnt", 32'(bus.gnt), 32'b0010);
        bus.done = '0;
`endif

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) bus.req = N'($urandom);
            bus.done = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            tick();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
